// File: rtl/sw_debounce4_pkg.sv
// Shared constants and helpers for the switch debouncer.
// The counter width comes from the stability interval.
package sw_debounce4_pkg;

  localparam int DEFAULT_STABLE_CNT = 1000000;

  // Smallest width whose range covers 0..stable_cnt-1 (valid for stable_cnt >= 2)
  function automatic int cnt_width(input int stable_cnt);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < stable_cnt) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/sw_debounce4_ch.sv
// One debounced switch channel: a two-flop synchroniser, a stability counter,
// the clean level, and one-cycle rise/fall strobes.
module debounce_ch
  import sw_debounce4_pkg::*;
#(
  parameter int STABLE_CNT = DEFAULT_STABLE_CNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sw,
  output logic o_sw,
  output logic o_rise,
  output logic o_fall
);

  localparam int                CNT_W   = cnt_width(STABLE_CNT);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CNT - 1);

  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sw;
  logic             r_rise;
  logic             r_fall;
  logic             w_differ;
  logic             w_expire;

  assign w_differ = r_s2 ^ r_sw;
  assign w_expire = w_differ && (r_cnt == CNT_MAX);

  // Bring the raw asynchronous level into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_sw;
      r_s2 <= r_s1;
    end
  end

  // Accept a new level only after it has disagreed with the output long enough;
  // any return to the current level restarts the interval
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_sw   <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_expire) begin
        r_cnt  <= '0;
        r_sw   <= r_s2;
        r_rise <= r_s2;
        r_fall <= ~r_s2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_sw   = r_sw;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/sw_debounce4.sv
// N independent debounced switch channels; bits 0..3 of sw_out feed the
// downstream a..d inputs.
module sw_debounce4
  import sw_debounce4_pkg::*;
#(
  parameter int N          = 4,
  parameter int STABLE_CNT = DEFAULT_STABLE_CNT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sw_in,
  output logic [N-1:0] sw_out,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  for (genvar g = 0; g < N; g++) begin : g_ch
    debounce_ch #(
      .STABLE_CNT(STABLE_CNT)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .i_sw  (sw_in[g]),
      .o_sw  (sw_out[g]),
      .o_rise(rise[g]),
      .o_fall(fall[g])
    );
  end

endmodule

// File: tb/tb_sw_debounce4.sv
// Cycle-by-cycle bench for sw_debounce4 with a short stability interval.
module tb_sw_debounce4;

  localparam int N  = 4;
  localparam int SC = 4;

  typedef struct {
    logic       rst;
    logic [3:0] sw;
    logic [3:0] out;
    logic [3:0] ri;
    logic [3:0] fa;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] sw_in;
  logic [N-1:0] sw_out;
  logic [N-1:0] rise;
  logic [N-1:0] fall;

  vec_t  tbl[$];
  vec_t  sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  string tag;

  sw_debounce4 #(.N(N), .STABLE_CNT(SC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw_in (sw_in),
    .sw_out(sw_out),
    .rise  (rise),
    .fall  (fall)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %h expected %h", tag, nm, act, exp);
    end
  endtask

  // Append n identical cycles to the vector table
  task automatic add(input int n, input logic r, input logic [3:0] s,
                     input logic [3:0] o, input logic [3:0] ri, input logic [3:0] fa);
    vec_t v;
    v.rst = r; v.sw = s; v.out = o; v.ri = ri; v.fa = fa;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  // Drive one cycle, queue what the outputs must be after the edge, then check
  task automatic cyc(input logic r, input logic [3:0] s,
                     input logic [3:0] o, input logic [3:0] ri, input logic [3:0] fa);
    vec_t e;
    vec_t got;
    rst_n = r;
    sw_in = s;
    e.rst = r; e.sw = s; e.out = o; e.ri = ri; e.fa = fa;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("sw_out", sw_out, got.out);
    check("rise",   rise,   got.ri);
    check("fall",   fall,   got.fa);
  endtask

  initial begin
    rst_n = 1'b0;
    sw_in = 4'h0;
    @(posedge clk);
    #1;

    // reset hold with all switches high
    add(10, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0);
    // release: new level first sampled on the next edge, accepted 5 edges later
    add(5, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0);
    add(1, 1'b1, 4'hF, 4'hF, 4'hF, 4'h0);
    add(3, 1'b1, 4'hF, 4'hF, 4'h0, 4'h0);
    add(5, 1'b1, 4'h0, 4'hF, 4'h0, 4'h0);
    add(1, 1'b1, 4'h0, 4'h0, 4'h0, 4'hF);
    add(3, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    // clean press and release on channel 0
    add(5, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0);
    add(1, 1'b1, 4'h1, 4'h1, 4'h1, 4'h0);
    add(4, 1'b1, 4'h1, 4'h1, 4'h0, 4'h0);
    add(5, 1'b1, 4'h0, 4'h1, 4'h0, 4'h0);
    add(1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h1);
    add(3, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    // 3-cycle glitch on channel 2 is rejected
    add(3, 1'b1, 4'h4, 4'h0, 4'h0, 4'h0);
    add(8, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    // 4-cycle pulse on channel 2 is just long enough, then filtered back down
    add(4, 1'b1, 4'h4, 4'h0, 4'h0, 4'h0);
    add(1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 1'b1, 4'h0, 4'h4, 4'h4, 4'h0);
    add(3, 1'b1, 4'h0, 4'h4, 4'h0, 4'h0);
    add(1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h4);
    add(2, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    // simultaneous change on all channels
    add(5, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0);
    add(1, 1'b1, 4'hF, 4'hF, 4'hF, 4'h0);
    add(2, 1'b1, 4'hF, 4'hF, 4'h0, 4'h0);
    add(5, 1'b1, 4'h0, 4'hF, 4'h0, 4'h0);
    add(1, 1'b1, 4'h0, 4'h0, 4'h0, 4'hF);
    add(2, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);

    foreach (tbl[i]) begin
      tag = $sformatf("row%0d", i);
      cyc(tbl[i].rst, tbl[i].sw, tbl[i].out, tbl[i].ri, tbl[i].fa);
    end

    // bounce on channel 1: 2-cycle toggles never reach the output
    tag = "bounce";
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, (((i / 2) % 2) == 0) ? 4'h2 : 4'h0, 4'h0, 4'h0, 4'h0);
    end
    for (int i = 0; i < 5; i++) cyc(1'b1, 4'h2, 4'h0, 4'h0, 4'h0);
    cyc(1'b1, 4'h2, 4'h2, 4'h2, 4'h0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'h2, 4'h2, 4'h0, 4'h0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 4'h0, 4'h2, 4'h0, 4'h0);
    cyc(1'b1, 4'h0, 4'h0, 4'h0, 4'h2);
    for (int i = 0; i < 2; i++) cyc(1'b1, 4'h0, 4'h0, 4'h0, 4'h0);

    // reset mid-count on channel 3 discards progress
    tag = "rst_mid";
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'h8, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'h8, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 4'h8, 4'h0, 4'h0, 4'h0);
    cyc(1'b1, 4'h8, 4'h8, 4'h8, 4'h0);
    for (int i = 0; i < 2; i++) cyc(1'b1, 4'h8, 4'h8, 4'h0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
